// File: rtl/sr04_multi_ranger.sv
// Round-robin HC-SR04 ranging engine: pings one sensor at a time and converts echo width (us) to cm per channel.
// Results land one cycle after echo fall or timeout; no backpressure, iStart is ignored while busy. Define SR04_AVG_EN for 2-sample averaging.
module sr04_multi_ranger #(
    parameter int NUM_CH             = 4,
    parameter int DIST_W             = 10,
    parameter int TRIG_US            = 10,
    parameter int ECHO_TIMEOUT_US    = 30000,
    parameter int MEASURE_TIMEOUT_US = 30000,
    parameter int US_PER_CM          = 58,
    parameter int HOLDOFF_US         = 60000
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iTickUs,
    input  logic [NUM_CH-1:0]        iEcho,
    input  logic                     iStart,
    input  logic                     iContinuous,
    output logic [NUM_CH-1:0]        oTrig,
    output logic [NUM_CH*DIST_W-1:0] oDistanceCm,
    output logic [NUM_CH-1:0]        oValid,
    output logic [NUM_CH-1:0]        oTimeout,
    output logic [2:0]               oChannel,
    output logic                     oBusy,
    output logic                     oScanDone
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SUB_W  = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
    localparam int MAX_A  = (TRIG_US > ECHO_TIMEOUT_US) ? TRIG_US : ECHO_TIMEOUT_US;
    localparam int MAX_B  = (MEASURE_TIMEOUT_US > HOLDOFF_US) ? MEASURE_TIMEOUT_US : HOLDOFF_US;
    localparam int MAX_US = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W  = $clog2(MAX_US + 1);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0]  ECHO_LAST = CNT_W'(ECHO_TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0]  MEAS_LAST = CNT_W'(MEASURE_TIMEOUT_US - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLDOFF_US - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;

    typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT, S_MEAS, S_STORE, S_HOLD} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SUB_W-1:0]    sub_q, sub_d;
    logic [DIST_W-1:0]   dist_q, dist_d;
    logic                tmo_q, tmo_d;
    logic                done_q, done_d;
    logic [NUM_CH-1:0]   sync1_q, sync2_q, prev_q;
    logic [DIST_W-1:0]   mem_q [NUM_CH];
    logic [DIST_W-1:0]   mem_d [NUM_CH];
    logic [NUM_CH-1:0]   valid_q, valid_d, tflag_q, tflag_d;
`ifdef SR04_AVG_EN
    logic [NUM_CH-1:0]   first_q, first_d;
    logic [DIST_W:0]     avg_sum;
    assign avg_sum = {1'b0, mem_q[ch_q]} + {1'b0, dist_q};
`endif

    logic echo_s, rise, fall, go, trig_end, wait_tmo, meas_tick, meas_tmo, hold_end, last_ch;

    // Edge detection compares the synced echo against one more delayed copy.
    assign echo_s    = sync2_q[ch_q];
    assign rise      = echo_s & ~prev_q[ch_q];
    assign fall      = ~echo_s & prev_q[ch_q];
    assign go        = iStart | iContinuous;
    assign trig_end  = iTickUs && (cnt_q == TRIG_LAST);
    assign wait_tmo  = iTickUs && !rise && (cnt_q == ECHO_LAST);
    assign meas_tick = iTickUs & echo_s;
    assign meas_tmo  = meas_tick && (cnt_q == MEAS_LAST);
    assign hold_end  = iTickUs && (cnt_q == HOLD_LAST);
    assign last_ch   = (ch_q == CH_LAST);

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go) state_d = S_TRIG;
            S_TRIG:  if (trig_end) state_d = S_WAIT;
            S_WAIT:  if (rise) state_d = S_MEAS;
                     else if (wait_tmo) state_d = S_STORE;
            S_MEAS:  if (fall || meas_tmo) state_d = S_STORE;
            S_STORE: state_d = S_HOLD;
            S_HOLD:  if (hold_end) state_d = last_ch ? S_IDLE : S_TRIG;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oTrig = '0;
        if (state_q == S_TRIG) oTrig[ch_q] = 1'b1;
        oBusy = (state_q != S_IDLE);
    end

    always_comb begin
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        dist_d  = dist_q;
        tmo_d   = tmo_q;
        done_d  = 1'b0;
        mem_d   = mem_q;
        valid_d = valid_q;
        tflag_d = tflag_q;
`ifdef SR04_AVG_EN
        first_d = first_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    ch_d  = '0;
                    cnt_d = '0;
                end
            end
            S_TRIG: begin
                tmo_d = 1'b0;
                if (iTickUs) cnt_d = trig_end ? '0 : cnt_q + CNT_W'(1);
            end
            S_WAIT: begin
                if (rise) begin
                    cnt_d  = '0;
                    sub_d  = '0;
                    dist_d = '0;
                end else if (iTickUs) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (wait_tmo) tmo_d = 1'b1;
                end
            end
            S_MEAS: begin
                if (meas_tick) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (dist_q != DIST_MAX) dist_d = dist_q + DIST_W'(1);
                    end else begin
                        sub_d = sub_q + SUB_W'(1);
                    end
                    if (meas_tmo) tmo_d = 1'b1;
                end
            end
            S_STORE: begin
                cnt_d = '0;
                if (tmo_q) begin
                    valid_d[ch_q] = 1'b0;
                    tflag_d[ch_q] = 1'b1;
`ifdef SR04_AVG_EN
                    first_d[ch_q] = 1'b1;
`endif
                end else begin
                    valid_d[ch_q] = 1'b1;
                    tflag_d[ch_q] = 1'b0;
`ifdef SR04_AVG_EN
                    mem_d[ch_q]   = first_q[ch_q] ? dist_q : DIST_W'(avg_sum >> 1);
                    first_d[ch_q] = 1'b0;
`else
                    mem_d[ch_q]   = dist_q;
`endif
                end
            end
            S_HOLD: begin
                if (iTickUs) cnt_d = cnt_q + CNT_W'(1);
                if (hold_end) begin
                    cnt_d = '0;
                    if (last_ch) done_d = 1'b1;
                    else         ch_d   = ch_q + CH_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ch_q    <= '0;
            cnt_q   <= '0;
            sub_q   <= '0;
            dist_q  <= '0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            valid_q <= '0;
            tflag_q <= '0;
            for (int k = 0; k < NUM_CH; k++) mem_q[k] <= '0;
`ifdef SR04_AVG_EN
            first_q <= '1;
`endif
        end else begin
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
            dist_q  <= dist_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            sync1_q <= iEcho;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            valid_q <= valid_d;
            tflag_q <= tflag_d;
            mem_q   <= mem_d;
`ifdef SR04_AVG_EN
            first_q <= first_d;
`endif
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_dist
        assign oDistanceCm[k*DIST_W +: DIST_W] = mem_q[k];
    end

    assign oChannel  = 3'(ch_q);
    assign oValid    = valid_q;
    assign oTimeout  = tflag_q;
    assign oScanDone = done_q;

endmodule

// File: tb/tb_sr04_multi_ranger.sv
// Bench for sr04_multi_ranger: directed and randomized echo widths checked against a per-channel distance model.
module tb_sr04_multi_ranger;

    localparam int NCH  = 3;
    localparam int DW   = 5;
    localparam int TRIG = 10;
    localparam int ETO  = 100;
    localparam int MTO  = 1900;
    localparam int UPC  = 58;
    localparam int HOLD = 20;
    localparam int DMAX = (1 << DW) - 1;

    logic              iClk = 1'b0;
    logic              iRst, iTickUs, iStart, iContinuous;
    logic [NCH-1:0]    iEcho;
    logic [NCH-1:0]    oTrig, oValid, oTimeout;
    logic [NCH*DW-1:0] oDistanceCm;
    logic [2:0]        oChannel;
    logic              oBusy, oScanDone;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;
    int overlap     = 0;
    int exp_dist[NCH];
    int exp_val[NCH];
    int exp_tmo[NCH];
    int first[NCH];
    int lens[NCH];

    sr04_multi_ranger #(
        .NUM_CH(NCH), .DIST_W(DW), .TRIG_US(TRIG), .ECHO_TIMEOUT_US(ETO),
        .MEASURE_TIMEOUT_US(MTO), .US_PER_CM(UPC), .HOLDOFF_US(HOLD)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iTickUs(iTickUs), .iEcho(iEcho),
        .iStart(iStart), .iContinuous(iContinuous), .oTrig(oTrig),
        .oDistanceCm(oDistanceCm), .oValid(oValid), .oTimeout(oTimeout),
        .oChannel(oChannel), .oBusy(oBusy), .oScanDone(oScanDone)
    );

    always #5 iClk = ~iClk;

    // 1 us tick every second clock, changed just after the active edge.
    initial begin
        iTickUs = 1'b0;
        forever begin
            @(posedge iClk);
            #1 iTickUs = ~iTickUs;
        end
    end

    initial begin
        forever begin
            @(negedge iClk);
            if (oScanDone === 1'b1) done_cnt++;
            if ($countones(oTrig) > 1) overlap++;
        end
    end

    initial begin
        #950000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            exp_dist[c] = 0; exp_val[c] = 0; exp_tmo[c] = 0; first[c] = 1;
        end
    endfunction

    function automatic void model(input int ch, input int len);
        int raw;
        if (len < 0 || len >= MTO) begin
            exp_val[ch] = 0; exp_tmo[ch] = 1; first[ch] = 1;
        end else begin
            raw = len / UPC;
            if (raw > DMAX) raw = DMAX;
`ifdef SR04_AVG_EN
            exp_dist[ch] = (first[ch] != 0) ? raw : (exp_dist[ch] + raw) / 2;
`else
            exp_dist[ch] = raw;
`endif
            first[ch] = 0; exp_val[ch] = 1; exp_tmo[ch] = 0;
        end
    endfunction

    // len < 0 means the sensor never answers.
    task automatic service(input int ch, input int len);
        int g, tk, d;
        logic [NCH-1:0] oh;
        oh = '0;
        oh[ch] = 1'b1;
        g = 0;
        while (oTrig !== oh && g < 20000) begin @(negedge iClk); g++; end
        chk($sformatf("trig_on%0d", ch), oTrig, oh);
        chk($sformatf("chan%0d", ch), oChannel, ch);
        chk($sformatf("busy%0d", ch), oBusy, 1);
        tk = 0; g = 0;
        while (oTrig !== '0 && g < 20000) begin
            if (iTickUs) tk++;
            @(negedge iClk);
            g++;
        end
        chk($sformatf("trig_width%0d", ch), tk, TRIG);
        if (len >= 0) begin
            if (iTickUs) @(negedge iClk);
            d = $urandom_range(0, 15);
            repeat (2 * d) @(negedge iClk);
            iEcho[ch] = 1'b1;
            repeat (2 * len) @(negedge iClk);
            iEcho[ch] = 1'b0;
        end
        model(ch, len);
    endtask

    task automatic run_scan(input bit pulse_start, input bit poke, input bit drop_cont);
        int g;
        if (pulse_start) begin iStart = 1'b1; @(negedge iClk); iStart = 1'b0; end
        for (int ch = 0; ch < NCH; ch++) begin
            service(ch, lens[ch]);
            if (ch == 0 && poke) begin iStart = 1'b1; @(negedge iClk); iStart = 1'b0; end
            if (ch == 0 && drop_cont) iContinuous = 1'b0;
        end
        g = 0;
        while (oScanDone !== 1'b1 && g < 20000) begin @(negedge iClk); g++; end
        chk("scan_done", oScanDone, 1);
        chk("busy_at_done", oBusy, 0);
        chk("chan_hold", oChannel, NCH - 1);
        for (int ch = 0; ch < NCH; ch++) begin
            chk($sformatf("dist%0d", ch), oDistanceCm[ch*DW +: DW], exp_dist[ch]);
            chk($sformatf("valid%0d", ch), oValid[ch], exp_val[ch]);
            chk($sformatf("tmo%0d", ch), oTimeout[ch], exp_tmo[ch]);
        end
    endtask

    task automatic rand_lens();
        for (int ch = 0; ch < NCH; ch++)
            lens[ch] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(58, 700));
    endtask

    initial begin
        int g;
        iRst = 1'b1; iStart = 1'b0; iContinuous = 1'b0; iEcho = '0;
        model_reset();
        repeat (4) @(negedge iClk);
        chk("rst_trig", oTrig, 0);
        chk("rst_dist", oDistanceCm, 0);
        chk("rst_valid", oValid, 0);
        chk("rst_tmo", oTimeout, 0);
        chk("rst_chan", oChannel, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oScanDone, 0);
        iRst = 1'b0;
        repeat (20) @(negedge iClk);
        chk("idle_no_start", oBusy, 0);

        // Reset asserted while channel 0 is triggering.
        iStart = 1'b1; @(negedge iClk); iStart = 1'b0;
        g = 0;
        while (oTrig !== 3'b001 && g < 1000) begin @(negedge iClk); g++; end
        chk("trig_before_rst", oTrig, 3'b001);
        @(negedge iClk);
        iRst = 1'b1;
        @(negedge iClk);
        chk("rst_mid_trig", oTrig, 0);
        chk("rst_mid_busy", oBusy, 0);
        chk("rst_mid_chan", oChannel, 0);
        chk("rst_mid_valid", oValid, 0);
        iRst = 1'b0;
        repeat (40) @(negedge iClk);
        chk("post_rst_idle", oBusy, 0);
        chk("post_rst_trig", oTrig, 0);

        lens = '{580, 1160, 300};
        run_scan(1'b1, 1'b1, 1'b0);
        repeat (60) @(negedge iClk);
        chk("start_ignored_busy", oBusy, 0);

        lens = '{579, -1, 1880};
        run_scan(1'b1, 1'b0, 1'b0);

        lens = '{MTO + 5, MTO - 1, 57};
        run_scan(1'b1, 1'b1, 1'b0);

        rand_lens();
        run_scan(1'b1, 1'b0, 1'b0);

        iContinuous = 1'b1;
        for (int s = 0; s < 4; s++) begin
            rand_lens();
            run_scan(1'b0, s == 1, s == 3);
        end
        repeat (100) @(negedge iClk);
        chk("cont_stopped", oBusy, 0);
        chk("scan_done_count", done_cnt, 8);
        chk("trig_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
